// File: rtl/handshake_dst_sink_pkg.sv
// Shared state encoding for the handshake synchronizer endpoints.
// The source-side FSM uses the same package, so keep the encodings stable.
package handshake_dst_sink_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_READY  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BACKPR = 2'd2
    } hs_state_e;

    function automatic logic state_is_busy(input hs_state_e s);
        return s != ST_READY;
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// Show-ahead FIFO for the destination sink.
// Occupancy is tracked apart from the pointers, so full and empty are never ambiguous.
module sink_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     count_next_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_i && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage carries no reset; stale entries are never visible because the
    // head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign valid_o      = (count_q != '0);
    assign head_o       = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/handshake_dst_sink.sv
// Destination-side consumer of the handshake synchronizer: captures one word per
// handshake, suppresses repeated dvalid strobes, and throttles via dbusy.
//
// state     | meaning
// ST_READY  | idle, next dvalid is captured
// ST_HOLD   | hold-off after a capture, dvalid treated as a duplicate
// ST_BACKPR | FIFO nearly full, any dvalid is a protocol error
module handshake_dst_sink
    import handshake_dst_sink_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int HOLD  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       dvalid_i,
    input  logic [WIDTH-1:0]           dout_i,
    output logic                       dbusy_o,
    output logic                       out_valid_o,
    output logic [WIDTH-1:0]           out_data_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic [15:0]                rx_count_o,
    output logic                       err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    hs_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   rx_q, rx_d;
    logic          err_q, err_d;
    logic          dbusy_q;

    logic          push;
    logic          pop;
    logic          level_hi;
    logic [CW-1:0] count_next;

    assign push     = (state_q == ST_READY) && dvalid_i;
    assign pop      = out_valid_o && out_ready_i;
    assign level_hi = (count_next >= CW'(DEPTH - 1));

    sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_data_i  (dout_i),
        .pop_i        (pop),
        .valid_o      (out_valid_o),
        .head_o       (out_data_o),
        .count_o      (fifo_count_o),
        .count_next_o (count_next)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        err_d   = err_q;
        rx_d    = push ? rx_q + 16'd1 : rx_q;
        case (state_q)
            ST_READY: begin
                if (dvalid_i) begin
                    state_d = ST_HOLD;
                    hold_d  = HW'(HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else begin
                    state_d = level_hi ? ST_BACKPR : ST_READY;
                end
            end
            ST_BACKPR: begin
                // Entering READY only below DEPTH-1 guarantees the next capture has room.
                if (dvalid_i) begin
                    err_d = 1'b1;
                end
                if (!level_hi) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_READY;
            hold_q  <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            dbusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            dbusy_q <= state_is_busy(state_d);
        end
    end

    assign dbusy_o    = dbusy_q;
    assign rx_count_o = rx_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_handshake_dst_sink.sv
// Directed bench for handshake_dst_sink; expected words are queued at stimulus
// time and a negedge monitor checks every word popped downstream.
module tb_handshake_dst_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dvalid = 1'b0;
    logic [31:0] dout = '0;
    logic        out_ready = 1'b0;
    logic        dbusy;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  fifo_count;
    logic [15:0] rx_count;
    logic        err;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q [$];

    handshake_dst_sink #(
        .WIDTH (32),
        .DEPTH (4),
        .HOLD  (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .dvalid_i     (dvalid),
        .dout_i       (dout),
        .dbusy_o      (dbusy),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .fifo_count_o (fifo_count),
        .rx_count_o   (rx_count),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input bit accepted);
        dvalid = 1'b1;
        dout   = d;
        tick();
        dvalid = 1'b0;
        dout   = '0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic wait_not_busy(output int cycles);
        cycles = 0;
        while (dbusy && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // Scoreboard: one pop per clock edge where valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL stream: got unexpected word %h expected no word", out_data);
            end else begin
                check("stream", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int maxc;

        // reset with a live dvalid
        rst = 1'b1; dvalid = 1'b1; dout = 32'h1234;
        repeat (2) tick();
        check("rst_dbusy", dbusy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_err", err, 0);
        rst = 1'b0; dvalid = 1'b0; dout = '0;
        tick();
        check("post_rst_dbusy", dbusy, 0);
        check("post_rst_fifo_count", fifo_count, 0);

        // single word, 1-cycle latency and 8-cycle hold-off
        send_word(32'hDEADBEEF, 1'b1);
        check("single_out_valid", out_valid, 1);
        check("single_out_data", out_data, 32'hDEADBEEF);
        check("single_fifo_count", fifo_count, 1);
        check("single_rx_count", rx_count, 1);
        check("single_dbusy", dbusy, 1);
        wait_not_busy(n);
        check("single_dbusy_cycles", n, 8);
        drain(1);
        check("single_drained_count", fifo_count, 0);
        check("single_drained_valid", out_valid, 0);

        // dvalid held for 5 cycles: duplicates suppressed
        dvalid = 1'b1; dout = 32'hA5A5A5A5;
        repeat (5) tick();
        dvalid = 1'b0; dout = '0;
        exp_q.push_back(32'hA5A5A5A5);
        wait_not_busy(n);
        check("dup_release", dbusy, 0);
        check("dup_fifo_count", fifo_count, 1);
        check("dup_rx_count", rx_count, 2);
        check("dup_err", err, 0);
        drain(1);

        // three words with no downstream ready -> BACKPR
        send_word(32'h11111111, 1'b1);
        repeat (8) tick();
        send_word(32'h22222222, 1'b1);
        repeat (8) tick();
        check("bp_ready_before_third", dbusy, 0);
        send_word(32'h33333333, 1'b1);
        repeat (8) tick();
        check("bp_dbusy", dbusy, 1);
        check("bp_fifo_count", fifo_count, 3);
        check("bp_rx_count", rx_count, 5);
        repeat (4) tick();
        check("bp_dbusy_stays", dbusy, 1);

        // dvalid during BACKPR is dropped and flagged
        send_word(32'hBAD0BAD0, 1'b0);
        check("perr_err", err, 1);
        check("perr_fifo_count", fifo_count, 3);
        check("perr_rx_count", rx_count, 5);
        tick();
        check("perr_err_sticky", err, 1);

        // one pop releases backpressure
        drain(1);
        check("bp_pop_count", fifo_count, 2);
        check("bp_pop_dbusy", dbusy, 0);
        check("bp_pop_head", out_data, 32'h22222222);
        drain(3);
        check("bp_drained", fifo_count, 0);

        // streaming with simultaneous push/pop and pointer wrap
        out_ready = 1'b1;
        maxc = 0;
        for (int i = 1; i <= 10; i++) begin
            send_word(32'(i), 1'b1);
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            repeat (8) begin
                tick();
                if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            end
        end
        out_ready = 1'b0;
        check("stream_max_count", maxc, 1);
        check("stream_rx_count", rx_count, 15);
        check("stream_final_count", fifo_count, 0);
        check("stream_all_seen", exp_q.size(), 0);
        check("stream_err_sticky", err, 1);

        // reset mid-operation
        send_word(32'h00000077, 1'b0);
        check("mid_pre_count", fifo_count, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_dbusy", dbusy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_rx", rx_count, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        tick();
        check("mid_post_dbusy", dbusy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
